wb_uart_rx: RTL and testbench
=============================

Name: wb_uart_rx

Overview:
- Wishbone-attached UART receiver for the servant SoC. It is the receive-side counterpart of the firmware bit-banged TX line.
- Deserialises 8N1 frames from an asynchronous rx pin into a one-byte holding register.
- Exposes data and status to the SERV CPU over a minimal 8-bit Wishbone slave port.
- Raises a level interrupt while a byte is waiting.

Parameters:
- CLKS_PER_BIT, 139, wb_clk cycles per bit (16 MHz / 115200); must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2, cycles from start-bit falling edge to the start-bit mid-sample.

Ports:
- wb_clk  input  1  system clock; all logic on its rising edge.
- wb_rst_n  input  1  synchronous, active-low reset.
- rx  input  1  asynchronous serial input; idles high.
- wb_adr  input  2  register select: 0 = DATA, 1 = STATUS.
- wb_cyc  input  1  Wishbone cycle/strobe (combined).
- wb_we  input  1  write enable; writes are acknowledged and ignored.
- wb_rdt  output  8  read data, valid while wb_ack = 1.
- wb_ack  output  1  one-cycle acknowledge.
- irq  output  1  high while a received byte is unread (= ready).

Behaviour:
- Reset (wb_rst_n = 0 at a clock edge):
  - wb_rdt = 0, wb_ack = 0, irq = 0.
  - ready = 0, overrun = 0, ferr = 0, data = 0.
  - Synchroniser flops = 1; FSM = IDLE; bit counter and baud counter = 0.
  - Reset mid-frame aborts the frame with no status update. The next falling edge after release starts a fresh frame.
- Synchroniser: two flops on rx; the FSM uses only the second flop (rxs). Input-to-FSM latency is 2 cycles.
- Baud counter:
  - When an event is scheduled, the counter is loaded with N-1 and decrements each cycle.
  - The sample strobe fires in the cycle the counter is 0.
- FSM states:
  - IDLE: on rxs = 0, load HALF_BIT-1 and go to START.
  - START: at the strobe, if rxs = 1 (glitch), go to IDLE with no status change. Otherwise load CLKS_PER_BIT-1, clear the bit counter, and go to DATA.
  - DATA: at each strobe, shift rxs into bit 7 of the shift register (LSB first) and reload CLKS_PER_BIT-1. After the 8th sample, go to STOP.
  - STOP, strobe with rxs = 1: deliver the byte (see holding register) and go to IDLE.
  - STOP, strobe with rxs = 0: set ferr, discard the byte, and go to BREAK.
  - BREAK: wait for rxs = 1, then go to IDLE. A held-low line produces exactly one ferr.
- Holding register on delivery:
  - ready = 0: data <= shift, ready <= 1.
  - ready = 1: overrun <= 1; data unchanged; the new byte is dropped.
  - Delivery in the same cycle as an acked DATA read: the new byte is loaded, ready stays 1, overrun is not set.
- Wishbone:
  - wb_ack <= wb_cyc & !wb_ack, giving exactly 1 cycle of latency and a single-cycle pulse. Back-to-back requests are therefore acked every other cycle.
  - wb_rdt is registered alongside wb_ack and is 0 whenever wb_ack = 0.
- Register reads:
  - Address 0: wb_rdt = data; ready is cleared in the ack cycle.
  - Address 1: wb_rdt = {5'b0, ferr, overrun, ready}; ferr and overrun are cleared in the ack cycle. A new ferr or overrun in the same cycle wins (the bit stays set).
  - Addresses 2 and 3: read 0.
  - Writes have no side effects.
- irq = ready, combinational from the ready flop.

Test Plan (CLKS_PER_BIT = 8 unless stated):
- Reset: hold wb_rst_n low for 3 cycles with rx = 1 -> wb_ack, wb_rdt and irq all 0; a STATUS read returns 0x00.
- Single byte: drive frame 0x55 (8 cycles/bit), then read DATA -> irq rises 1 cycle after the stop-bit mid-sample; DATA = 0x55; irq is 0 in the cycle after ack; STATUS then reads 0x00.
- Overrun: send 0xA5 then 0x3C without reading -> DATA = 0xA5; STATUS = 0x03 before the DATA read and 0x00 after a STATUS read.
- Framing error: send 0x81 with a stop bit of 0, then hold rx low for 40 cycles, then release -> STATUS = 0x04 with ready = 0; only one ferr is recorded; the following frame 0x12 is received correctly.
- Glitch: pulse rx low for 2 cycles -> FSM returns to IDLE; no ready and no ferr.
- Race and reset: schedule a DATA read ack in the exact cycle the second byte delivers -> ready stays 1, overrun = 0, next DATA read = second byte. Separately, assert wb_rst_n low mid-byte -> all state 0; the next frame 0x7E is received intact.

Source files
------------

// File: rtl/wb_uart_rx.sv
// 8N1 UART receiver with a one-byte holding register behind a minimal 8-bit
// Wishbone slave. irq stays high while a received byte is unread.
module wb_uart_rx #(
  parameter int CLKS_PER_BIT = 139,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  input  logic       rx,
  input  logic [1:0] wb_adr,
  input  logic       wb_cyc,
  input  logic       wb_we,
  output logic [7:0] wb_rdt,
  output logic       wb_ack,
  output logic       irq
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
  logic          overrun_q, overrun_d;
  logic          ferr_q, ferr_d;
  logic          ack_q, ack_d;
  logic [7:0]    rdt_q, rdt_d;

  logic rxs;
  logic strobe;
  logic deliver;
  logic ferr_set;
  logic take;
  logic rd_data;
  logic rd_stat;

  assign rxs    = sync2_q;
  assign strobe = (baud_q == '0);

  always_comb begin
    sync1_d   = rx;
    sync2_d   = sync1_q;
    state_d   = state_q;
    baud_d    = (baud_q != '0) ? baud_q - 1'b1 : baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
    ferr_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          baud_d  = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (strobe) begin
          if (rxs) begin
            state_d = IDLE;
          end else begin
            baud_d    = FULL_LOAD;
            bit_cnt_d = 3'd0;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (strobe) begin
          shift_d   = {rxs, shift_q[7:1]};
          baud_d    = FULL_LOAD;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          if (rxs) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A read takes effect in the cycle the request is accepted, which is also
  // the cycle that registers wb_rdt, so the value returned and the side
  // effect always refer to the same holding-register state.
  always_comb begin
    take      = wb_cyc & ~ack_q;
    rd_data   = take & ~wb_we & (wb_adr == 2'd0);
    rd_stat   = take & ~wb_we & (wb_adr == 2'd1);
    ack_d     = take;
    rdt_d     = 8'h00;
    ready_d   = ready_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    ferr_d    = ferr_q;
    if (take && !wb_we) begin
      case (wb_adr)
        2'd0:    rdt_d = data_q;
        2'd1:    rdt_d = {5'b0, ferr_q, overrun_q, ready_q};
        default: rdt_d = 8'h00;
      endcase
    end
    if (rd_data) ready_d = 1'b0;
    if (rd_stat) begin
      overrun_d = 1'b0;
      ferr_d    = 1'b0;
    end
    if (deliver) begin
      if (!ready_q || rd_data) begin
        data_d  = shift_q;
        ready_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (ferr_set) ferr_d = 1'b1;
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
      ack_q     <= 1'b0;
      rdt_q     <= 8'h00;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
      ack_q     <= ack_d;
      rdt_q     <= rdt_d;
    end
  end

  assign wb_ack = ack_q;
  assign wb_rdt = rdt_q;
  assign irq    = ready_q;

endmodule

// File: tb/tb_wb_uart_rx.sv
// Bench for wb_uart_rx: directed scenarios plus random frames and random bus
// traffic, checked every cycle against a frame-timing model of the receiver.
`timescale 1ns/1ps
module tb_wb_uart_rx;

  localparam int CPB         = 8;
  localparam int HALF        = CPB / 2;
  // Two synchroniser cycles, half a bit to the start mid-sample, nine full bits.
  localparam int DELIVER_LAT = 2 + HALF + 9 * CPB;

  logic       wb_clk   = 1'b0;
  logic       wb_rst_n = 1'b0;
  logic       rx       = 1'b1;
  logic [1:0] wb_adr   = 2'd0;
  logic       wb_cyc   = 1'b0;
  logic       wb_we    = 1'b0;
  logic [7:0] wb_rdt;
  logic       wb_ack;
  logic       irq;

  wb_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .rx      (rx),
    .wb_adr  (wb_adr),
    .wb_cyc  (wb_cyc),
    .wb_we   (wb_we),
    .wb_rdt  (wb_rdt),
    .wb_ack  (wb_ack),
    .irq     (irq)
  );

  always #5 wb_clk = ~wb_clk;

  int cyc_cnt = 0;
  always @(posedge wb_clk) cyc_cnt <= cyc_cnt + 1;

  int         n_checks    = 0;
  int         n_errors    = 0;
  int         pend_cycle  = -1;
  int         pend_kind   = 0;
  logic [7:0] pend_byte   = 8'h00;
  int         last_fall   = 0;
  bit         done        = 1'b0;
  bit         chk_en      = 1'b0;
  bit         frames_done = 1'b0;

  // Reference model: frame outcomes are scheduled by the sender at the cycle
  // the stop bit is sampled; the register file follows the documented rules.
  logic       m_ack = 1'b0, m_ready = 1'b0, m_overrun = 1'b0, m_ferr = 1'b0;
  logic [7:0] m_rdt = 8'h00, m_data = 8'h00, m_regval;
  wire m_take     = wb_cyc && !m_ack;
  wire m_rd_data  = m_take && !wb_we && (wb_adr == 2'd0);
  wire m_rd_stat  = m_take && !wb_we && (wb_adr == 2'd1);
  wire m_event    = (pend_kind != 0) && (cyc_cnt == pend_cycle);
  wire m_deliver  = m_event && (pend_kind == 1);
  wire m_ferr_new = m_event && (pend_kind == 2);

  always_comb begin
    m_regval = 8'h00;
    if (!wb_we) begin
      case (wb_adr)
        2'd0:    m_regval = m_data;
        2'd1:    m_regval = {5'b0, m_ferr, m_overrun, m_ready};
        default: m_regval = 8'h00;
      endcase
    end
  end

  always @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      m_ack <= 1'b0; m_rdt <= 8'h00; m_ready <= 1'b0;
      m_overrun <= 1'b0; m_ferr <= 1'b0; m_data <= 8'h00;
    end else begin
      m_ack     <= m_take;
      m_rdt     <= m_take ? m_regval : 8'h00;
      m_ready   <= m_deliver ? 1'b1 : (m_rd_data ? 1'b0 : m_ready);
      m_data    <= (m_deliver && (!m_ready || m_rd_data)) ? pend_byte : m_data;
      m_overrun <= (m_deliver && m_ready && !m_rd_data) ? 1'b1 : (m_rd_stat ? 1'b0 : m_overrun);
      m_ferr    <= m_ferr_new ? 1'b1 : (m_rd_stat ? 1'b0 : m_ferr);
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%02h, expected 0x%02h", name, cyc_cnt, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    @(negedge wb_clk);
    rx         = 1'b0;
    last_fall  = cyc_cnt;
    pend_byte  = b;
    pend_kind  = stop_bit ? 1 : 2;
    pend_cycle = cyc_cnt + DELIVER_LAT;
    repeat (CPB) @(negedge wb_clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge wb_clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge wb_clk);
  endtask

  task automatic readReg(input logic [1:0] adr, output logic [7:0] val);
    int n;
    @(negedge wb_clk);
    wb_cyc = 1'b1; wb_adr = adr; wb_we = 1'b0;
    n = 0;
    do begin
      @(negedge wb_clk);
      n++;
    end while (!wb_ack && n < 4);
    checkOutput("read_ack", {7'b0, wb_ack}, 8'h01);
    val    = wb_rdt;
    wb_cyc = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] v;
    fork
      begin
        while (!done) begin
          @(negedge wb_clk);
          if (chk_en) begin
            checkOutput("wb_ack", {7'b0, wb_ack}, {7'b0, m_ack});
            checkOutput("wb_rdt", wb_rdt, m_rdt);
            checkOutput("irq", {7'b0, irq}, {7'b0, m_ready});
          end
        end
      end
      begin
        // Reset
        @(negedge wb_clk);
        chk_en = 1'b1;
        repeat (2) @(negedge wb_clk);
        checkOutput("reset_ack", {7'b0, wb_ack}, 8'h00);
        checkOutput("reset_rdt", wb_rdt, 8'h00);
        checkOutput("reset_irq", {7'b0, irq}, 8'h00);
        wb_rst_n = 1'b1;
        readReg(2'd1, v);
        checkOutput("reset_status", v, 8'h00);

        // Single byte with irq timing
        fork
          applyStimulus(8'h55, 1'b1);
          begin
            @(negedge wb_clk);
            @(negedge wb_clk);
            while (cyc_cnt != last_fall + DELIVER_LAT) @(negedge wb_clk);
            checkOutput("irq_before_stop", {7'b0, irq}, 8'h00);
            @(negedge wb_clk);
            checkOutput("irq_after_stop", {7'b0, irq}, 8'h01);
          end
        join
        readReg(2'd0, v);
        checkOutput("single_data", v, 8'h55);
        @(negedge wb_clk);
        checkOutput("single_irq_clear", {7'b0, irq}, 8'h00);
        readReg(2'd1, v);
        checkOutput("single_status", v, 8'h00);

        // Overrun
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h3C, 1'b1);
        readReg(2'd1, v);
        checkOutput("ovr_status", v, 8'h03);
        readReg(2'd0, v);
        checkOutput("ovr_data", v, 8'hA5);
        readReg(2'd1, v);
        checkOutput("ovr_status_clear", v, 8'h00);

        // Framing error with a held-low line
        applyStimulus(8'h81, 1'b0);
        readReg(2'd1, v);
        checkOutput("ferr_status", v, 8'h04);
        repeat (38) @(negedge wb_clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge wb_clk);
        readReg(2'd1, v);
        checkOutput("ferr_single", v, 8'h00);
        applyStimulus(8'h12, 1'b1);
        readReg(2'd0, v);
        checkOutput("ferr_next_data", v, 8'h12);

        // Glitch
        @(negedge wb_clk);
        rx = 1'b0;
        repeat (2) @(negedge wb_clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge wb_clk);
        readReg(2'd1, v);
        checkOutput("glitch_status", v, 8'h00);

        // DATA read accepted in the exact delivery cycle
        applyStimulus(8'h11, 1'b1);
        fork
          applyStimulus(8'h22, 1'b1);
          begin
            @(negedge wb_clk);
            @(negedge wb_clk);
            while (cyc_cnt != last_fall + DELIVER_LAT) @(negedge wb_clk);
            wb_adr = 2'd0; wb_we = 1'b0; wb_cyc = 1'b1;
            @(negedge wb_clk);
            checkOutput("race_ack", {7'b0, wb_ack}, 8'h01);
            checkOutput("race_rdt", wb_rdt, 8'h11);
            wb_cyc = 1'b0;
          end
        join
        readReg(2'd1, v);
        checkOutput("race_status", v, 8'h01);
        readReg(2'd0, v);
        checkOutput("race_data", v, 8'h22);

        // Reset mid-frame with pending status
        applyStimulus(8'h99, 1'b1);
        applyStimulus(8'h66, 1'b1);
        @(negedge wb_clk);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge wb_clk);
        wb_rst_n = 1'b0;
        rx       = 1'b1;
        repeat (3) @(negedge wb_clk);
        checkOutput("midreset_irq", {7'b0, irq}, 8'h00);
        wb_rst_n = 1'b1;
        readReg(2'd1, v);
        checkOutput("midreset_status", v, 8'h00);
        applyStimulus(8'h7E, 1'b1);
        readReg(2'd0, v);
        checkOutput("midreset_data", v, 8'h7E);

        // Random frames against random bus traffic
        fork
          begin
            for (int i = 0; i < 40; i++) begin
              int kind;
              logic [7:0] b;
              kind = $urandom_range(0, 9);
              b    = 8'($urandom);
              if (kind < 7) begin
                applyStimulus(b, 1'b1);
              end else if (kind < 9) begin
                applyStimulus(b, 1'b0);
                repeat ($urandom_range(0, 40)) @(negedge wb_clk);
                rx = 1'b1;
              end else begin
                @(negedge wb_clk);
                rx = 1'b0;
                repeat ($urandom_range(1, HALF - 1)) @(negedge wb_clk);
                rx = 1'b1;
              end
              repeat ($urandom_range(CPB, 3 * CPB)) @(negedge wb_clk);
            end
            frames_done = 1'b1;
          end
          begin
            while (!frames_done) begin
              repeat ($urandom_range(0, 30)) @(negedge wb_clk);
              wb_adr = 2'($urandom_range(0, 3));
              wb_we  = ($urandom_range(0, 5) == 0);
              wb_cyc = 1'b1;
              repeat ($urandom_range(1, 3)) @(negedge wb_clk);
              wb_cyc = 1'b0;
            end
          end
        join
        repeat (4) @(negedge wb_clk);
        done = 1'b1;
      end
    join
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
